// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked frame, ack check.
// Optional feature macro: PS2_TX_ACK_CHECK_EN (when defined, a high DAT at the ack clock raises error_no_ack).
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  localparam int MAX_P = (INHIBIT_CYCLES > START_TIMEOUT) ?
                         ((INHIBIT_CYCLES > XFER_TIMEOUT) ? INHIBIT_CYCLES : XFER_TIMEOUT) :
                         ((START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT);
  localparam int CW = ($clog2(MAX_P) > 20) ? $clog2(MAX_P) : 20;
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_DATA,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
`ifdef PS2_TX_ACK_CHECK_EN
    S_ERR_NACK,
`endif
    S_ERR_TO
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      data_q, data_d;
  logic            clk_low_q, clk_low_d;
  logic            dat_low_q, dat_low_d;
  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            clk_prev_q;
  logic            clk_s, dat_s, fe;
  logic [15:0]     frame_bits;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fe    = clk_prev_q & ~clk_s;
  // Index 8 is odd parity; upper padding reads as released (1) so stray indices never pull the line.
  assign frame_bits = {7'h7f, ~^data_q, data_q};

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      clk_low_q  <= clk_low_d;
      dat_low_q  <= dat_low_d;
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (send_command) begin
          data_d  = the_command;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (cnt_q == START_LAST) begin
          state_d = S_ERR_TO;
        end else if (fe) begin
          state_d = S_DATA;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_DATA: begin
        if (cnt_q == XFER_LAST) begin
          state_d = S_ERR_TO;
        end else if (fe) begin
          if (idx_q == 4'd8) state_d = S_ACK;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      S_ACK: begin
        if (cnt_q == XFER_LAST) begin
          state_d = S_ERR_TO;
        end else if (fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
          state_d = dat_s ? S_ERR_NACK : S_WAIT_IDLE;
`else
          state_d = S_WAIT_IDLE;
`endif
        end
      end
      S_WAIT_IDLE: begin
        if (cnt_q == XFER_LAST)  state_d = S_ERR_TO;
        else if (clk_s && dat_s) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Pin enables are registered from the next state so the open-drain lines never glitch.
    clk_low_d = (state_d == S_INHIBIT);
    dat_low_d = 1'b0;
    case (state_d)
      S_INHIBIT: dat_low_d = (cnt_d == INH_LAST);
      S_RELEASE: dat_low_d = 1'b1;
      S_DATA:    dat_low_d = ~frame_bits[idx_d];
      default:   dat_low_d = 1'b0;
    endcase
  end

  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign busy = (state_q == S_INHIBIT) || (state_q == S_RELEASE) || (state_q == S_DATA) ||
                (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
  assign command_was_sent              = (state_q == S_DONE);
  assign error_communication_timed_out = (state_q == S_ERR_TO);
`ifdef PS2_TX_ACK_CHECK_EN
  assign error_no_ack = (state_q == S_ERR_NACK);
`else
  assign error_no_ack = 1'b0;
`endif

endmodule

// File: doc/ps2_command_tx.md
# ps2_command_tx

Host-to-device PS/2 transmitter that sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the FPGA to the attached keyboard. It is the transmit counterpart of the existing PS/2 receive path and shares the same PS2_CLK/PS2_DAT open-drain pins. The block runs the full host-request sequence: clock inhibit, start bit, device-clocked data/parity/stop, and acknowledge check. It reports success or failure with single-cycle pulses.

## Interface
- INHIBIT_CYCLES, 5000: cycles PS2_CLK is held low before the request (100 µs at 50 MHz).
- START_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT, 100000: maximum cycles from the first device falling edge to frame end (2 ms).

- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- the_command  in  8  byte to send; sampled only when a request is accepted.
- send_command  in  1  one-cycle request strobe.
- PS2_CLK  inout  1  open-drain: drives 0 or Z, never 1.
- PS2_DAT  inout  1  open-drain: drives 0 or Z, never 1.
- busy  out  1  high from request acceptance until return to IDLE.
- command_was_sent  out  1  one-cycle pulse on successful completion.
- error_communication_timed_out  out  1  one-cycle pulse on start or transfer timeout.
- error_no_ack  out  1  one-cycle pulse when the device does not acknowledge.

## Operation
- Pin inputs pass through 2-flop synchronizers. A device falling edge (fe) is a synchronized 1→0 transition of PS2_CLK.
- The frame is {stop=1, parity, data[7:0], start=0}. Parity is odd: ~^data.
- States:
  - IDLE: both lines Z. `send_command` latches the_command, sets busy, and moves to INHIBIT.
  - INHIBIT: CLK=0, DAT=Z for INHIBIT_CYCLES. In the last cycle, DAT is driven 0, then the block moves to RELEASE.
  - RELEASE: CLK=Z, DAT=0 (start bit). The counter is cleared.
    - fe moves to DATA with bit index 0.
    - START_TIMEOUT elapsing moves to ERR_TO.
  - DATA: each fe drives the next frame bit, in order data[0]…data[7], parity, stop (stop = release to Z).
    - A '1' bit is driven as Z; a '0' bit is driven as 0.
    - After the fe that releases stop, the block moves to ACK.
  - ACK: on the next fe, PS2_DAT is sampled. Sample 0 moves to WAIT_IDLE; sample 1 moves to ERR_NACK.
  - WAIT_IDLE: waits for synchronized CLK=1 and DAT=1, then pulses command_was_sent and moves to IDLE.
  - ERR_TO / ERR_NACK: both lines Z. The matching error output pulses for one cycle, then the block moves to IDLE.
- XFER_TIMEOUT counts from entry to DATA through WAIT_IDLE. When it elapses, the block moves to ERR_TO.
- A `send_command` while busy is ignored, with no queuing. The latched byte does not change mid-frame.
- Simultaneous `send_command` and the terminal pulse cycle: the request is ignored. It is accepted only in IDLE.
- Reset mid-frame: both lines go Z immediately (asynchronously), state goes to IDLE, and all outputs go 0. No pulse is emitted.

## Timing
- Reset values: busy=0, all pulses 0, PS2_CLK=Z, PS2_DAT=Z, state IDLE.
- From `send_command` at cycle N: busy=1 and PS2_CLK driven 0 at N+1.
- PS2_DAT is driven 0 at N+INHIBIT_CYCLES. PS2_CLK is released at N+INHIBIT_CYCLES+1.
- Data update occurs ≤3 cycles after a pin falling edge (2 synchronizer + 1 register). This is far inside the device's ≥30 µs clock-low phase.
- Success pulse: 3–4 cycles after both pins are high.
- busy falls in the same cycle as any terminal pulse.
- Counter width is ≥20 bits. Timeout fires when the count equals (parameter − 1).

## Configuration
- PS2_TX_ACK_CHECK_EN defined: ACK behaves as described above, and error_no_ack can pulse.
- PS2_TX_ACK_CHECK_EN undefined:
  - The ACK-state fe moves straight to WAIT_IDLE regardless of PS2_DAT.
  - error_no_ack is tied to 0 and the ERR_NACK state is absent.

## Test plan
- Reset check: assert reset mid-INHIBIT → PS2_CLK/PS2_DAT float high (pull-ups) within the same cycle; busy=0; no pulses.
- Send 0xED; device model clocks at 12.5 kHz and acks → sampled bits 0,1,0,1,1,0,1,1,1,1,1 (start, LSB-first data, parity 1, stop); command_was_sent pulses once; busy low afterwards.
- Send 0x01 → parity bit 0; send 0x00 → parity bit 1; both complete with a success pulse.
- Device never clocks after release → error_communication_timed_out pulses exactly START_TIMEOUT cycles after PS2_CLK release; lines Z.
- Device leaves DAT high at the ack clock (with PS2_TX_ACK_CHECK_EN) → error_no_ack pulses, no success pulse. Same stimulus without the macro → command_was_sent pulses.
- Send 0xF4, then pulse send_command with 0xFF mid-frame → bits on the wire are still 0xF4's, exactly one success pulse, no second frame.
